// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 timing defaults, capture-window defaults, pixel type and word decode (RGB565_MODE_EN selects RGB565, else grayscale)
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  localparam int WIN_W = 120;
  localparam int WIN_H = 120;
  localparam int WIN_X = 260;
  localparam int WIN_Y = 180;
  localparam logic [23:0] BORDER_RGB = 24'h000000;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  function automatic rgb_t to_rgb(logic [15:0] d);
`ifdef RGB565_MODE_EN
    return '{r: {d[15:11], d[15:13]}, g: {d[10:5], d[10:9]}, b: {d[4:0], d[4:2]}};
`else
    return '{r: d[7:0], g: d[7:0], b: d[7:0]};
`endif
  endfunction
endpackage

// File: rtl/framebuf_vga_reader_if.sv
// framebuf_vga_reader_if: frame-buffer read port, address out and data back one clk later
interface framebuf_vga_reader_if;
  logic [14:0] rdaddr;
  logic [15:0] rddata;
  modport master(output rdaddr, input rddata);
  modport slave(input rdaddr, output rddata);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters with active, sync and window flags decoded from them
module vga_timing import vga_pkg::*; #(
  parameter int HACTIVE = H_ACTIVE,
  parameter int HFP = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VACTIVE = V_ACTIVE,
  parameter int VFP = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP = V_BP,
  parameter int WIDTH = WIN_W,
  parameter int HEIGHT = WIN_H,
  parameter int XOFF = WIN_X,
  parameter int YOFF = WIN_Y
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       in_win
);
  localparam logic [9:0] HMAX = 10'(HACTIVE + HFP + HSYNC + HBP - 1);
  localparam logic [9:0] VMAX = 10'(VACTIVE + VFP + VSYNC + VBP - 1);
  localparam logic [9:0] HA = 10'(HACTIVE);
  localparam logic [9:0] VA = 10'(VACTIVE);
  localparam logic [9:0] HS0 = 10'(HACTIVE + HFP);
  localparam logic [9:0] HS1 = 10'(HACTIVE + HFP + HSYNC);
  localparam logic [9:0] VS0 = 10'(VACTIVE + VFP);
  localparam logic [9:0] VS1 = 10'(VACTIVE + VFP + VSYNC);
  localparam logic [9:0] X0 = 10'(XOFF);
  localparam logic [9:0] X1 = 10'(XOFF + WIDTH);
  localparam logic [9:0] Y0 = 10'(YOFF);
  localparam logic [9:0] Y1 = 10'(YOFF + HEIGHT);
  // pixel counter wraps at end of line and advances the line counter; both wrap together at frame end
  always_ff @(posedge clk)
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt == HMAX ? '0 : hcnt + 10'd1;
      if (hcnt == HMAX) vcnt <= vcnt == VMAX ? '0 : vcnt + 10'd1;
    end
  // region flags for the current counter position
  always_comb begin
    active = hcnt < HA && vcnt < VA;
    hs = hcnt >= HS0 && hcnt < HS1;
    vs = vcnt >= VS0 && vcnt < VS1;
    in_win = hcnt >= X0 && hcnt < X1 && vcnt >= Y0 && vcnt < Y1;
  end
endmodule

// File: rtl/framebuf_vga_reader.sv
// framebuf_vga_reader: VGA scan-out of the capture frame buffer, window centred on a border colour; RGB565_MODE_EN selects RGB565 words
module framebuf_vga_reader import vga_pkg::*; #(
  parameter int HACTIVE = H_ACTIVE,
  parameter int HFP = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VACTIVE = V_ACTIVE,
  parameter int VFP = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP = V_BP,
  parameter int WIDTH = WIN_W,
  parameter int HEIGHT = WIN_H,
  parameter int XOFF = WIN_X,
  parameter int YOFF = WIN_Y,
  parameter logic [23:0] BORDER = BORDER_RGB
) (
  input  logic                    clk,
  input  logic                    reset,
  framebuf_vga_reader_if.master   fb,
  output logic                    hsync_n,
  output logic                    vsync_n,
  output logic                    blank_n,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic                    frame_start
);
  logic [9:0] hcnt, vcnt;
  logic active, hs, vs, in_win;
  logic act1, hs1, vs1, win1, fs1;
  logic [6:0] wx, wy;
  rgb_t pix;
  vga_timing #(
    .HACTIVE(HACTIVE), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VACTIVE(VACTIVE), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XOFF(XOFF), .YOFF(YOFF)
  ) u_timing (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .active(active), .hs(hs), .vs(vs), .in_win(in_win)
  );
  // window-relative address from the counters; only the low 7 bits of the offset matter
  always_comb begin
    wx = hcnt[6:0] - 7'(XOFF);
    wy = vcnt[6:0] - 7'(YOFF);
    fb.rdaddr = in_win ? {wy, wx} : '0;
    pix = !act1 ? '0 : win1 ? to_rgb(fb.rddata) : BORDER;
  end
  // flags wait one cycle alongside the RAM read
  always_ff @(posedge clk)
    if (reset) {act1, hs1, vs1, win1, fs1} <= '0;
    else {act1, hs1, vs1, win1, fs1} <= {active, hs, vs, in_win, active && hcnt == '0 && vcnt == '0};
  // colour and sync leave together so they stay aligned
  always_ff @(posedge clk)
    if (reset) begin
      {r, g, b} <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {r, g, b} <= pix;
      hsync_n <= !hs1;
      vsync_n <= !vs1;
      blank_n <= act1;
      frame_start <= fs1;
    end
endmodule
